// File: rtl/mont_conv_sched.sv
// mont_conv_sched: round-robin arbiter in front of one shared Montgomery-domain
// conversion engine (num * 2^len mod modulus). It grants one requester at a time,
// rejects malformed requests without touching the engine, runs the engine and
// returns the tagged result.
// Optional build macro: MC_TIMEOUT_EN enables a watchdog. The watchdog aborts a
// WAIT that lasts TIMEOUT_CYC cycles without eng_end.
module mont_conv_sched #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_num,
  input  logic [NREQ*8-1:0]    req_len,
  input  logic [31:0]          modulus,
  output logic [NREQ-1:0]      done,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 eng_start,
  output logic [31:0]          eng_num,
  output logic [7:0]           eng_len,
  output logic [31:0]          eng_mod,
  input  logic                 eng_end,
  input  logic [31:0]          eng_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;

  state_t            r_state;
  logic [2:0]        r_ptr;
  logic [NREQ-1:0]   r_done;
  logic              r_rsp_valid;
  logic [2:0]        r_rsp_id;
  logic [31:0]       r_rsp_data;
  logic              r_rsp_err;
  logic              r_busy;
  logic              r_eng_start;
  logic [31:0]       r_eng_num;
  logic [7:0]        r_eng_len;
  logic [31:0]       r_eng_mod;
`ifdef MC_TIMEOUT_EN
  logic [15:0]       r_tmo_cnt;
`else
  // No watchdog in this build; the limit parameter is intentionally ignored.
  logic              w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC != 0);
`endif

  // Requester views padded to 8 entries so a 3-bit id indexes them without width games.
  logic [7:0]        w_req_pad;
  logic [31:0]       w_num [0:7];
  logic [7:0]        w_len [0:7];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slice
      if (gi < NREQ) begin : g_live
        assign w_req_pad[gi] = req[gi];
        assign w_num[gi]     = req_num[32*gi +: 32];
        assign w_len[gi]     = req_len[8*gi +: 8];
      end else begin : g_pad
        assign w_req_pad[gi] = 1'b0;
        assign w_num[gi]     = 32'd0;
        assign w_len[gi]     = 8'd0;
      end
    end
  endgenerate

  // Index addition modulo NREQ; both operands are already below NREQ.
  function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [3:0] b);
    logic [3:0] s;
    s = {1'b0, a} + b;
    if (s >= 4'(NREQ)) s = s - 4'(NREQ);
    return s[2:0];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] id);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (id == 3'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic        w_found;
  logic [2:0]  w_sel;
  logic [2:0]  w_cand;
  logic [31:0] w_sel_num;
  logic [7:0]  w_sel_len;
  logic        w_valid;

  // Round-robin pick: scan offsets from the far end so the nearest hit to ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 3'd0;
    w_cand  = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = wrap_add(r_ptr, 4'(k));
      if (w_req_pad[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_sel_num = w_num[w_sel];
  assign w_sel_len = w_len[w_sel];
  // The engine only handles len up to 31 and needs a nonzero modulus.
  assign w_valid   = (w_sel_len[7:5] == 3'd0) && (modulus != 32'd0);

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 3'd0;
      r_done      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 3'd0;
      r_rsp_data  <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_num   <= 32'd0;
      r_eng_len   <= 8'd0;
      r_eng_mod   <= 32'd0;
`ifdef MC_TIMEOUT_EN
      r_tmo_cnt   <= 16'd0;
`endif
    end else begin
      r_eng_start <= 1'b0;
      r_done      <= '0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_rsp_id <= w_sel;
            r_ptr    <= wrap_add(w_sel, 4'd1);
            r_busy   <= 1'b1;
            if (w_valid) begin
              r_eng_num   <= w_sel_num;
              r_eng_len   <= w_sel_len;
              r_eng_mod   <= modulus;
              r_eng_start <= 1'b1;
              r_state     <= ST_LAUNCH;
            end else begin
              // Rejected up front: answer immediately, engine stays idle.
              r_rsp_data  <= 32'd0;
              r_rsp_err   <= 1'b1;
              r_done      <= onehot(w_sel);
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_LAUNCH: begin
`ifdef MC_TIMEOUT_EN
          r_tmo_cnt <= 16'd0;
`endif
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_end) begin
            r_rsp_data  <= eng_out;
            r_rsp_err   <= 1'b0;
            r_done      <= onehot(r_rsp_id);
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
`ifdef MC_TIMEOUT_EN
          else if (r_tmo_cnt >= 16'(TIMEOUT_CYC - 1)) begin
            // Engine hung: give up; any later eng_end lands outside WAIT and is dropped.
            r_rsp_data  <= 32'd0;
            r_rsp_err   <= 1'b1;
            r_done      <= onehot(r_rsp_id);
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
`endif
        end
        ST_RESP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign eng_start = r_eng_start;
  assign eng_num   = r_eng_num;
  assign eng_len   = r_eng_len;
  assign eng_mod   = r_eng_mod;

endmodule

// File: doc/mont_conv_sched.md
# mont_conv_sched

Round-robin scheduler sharing one Montgomery-domain conversion engine (the `num*2^len mod modulus` long-division unit with `md_start`/`md_end` handshake) among NREQ requesters in the RSA datapath. It validates each request, launches the engine, waits for completion and returns the tagged result to the granted requester. The engine is reset by the same `rstn`.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 1023, engine watchdog limit in cycles (used only with MC_TIMEOUT_EN)
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- req_num  in  NREQ*32  operand per requester, slice i = [32*i+31:32*i]
- req_len  in  NREQ*8  exponent len per requester, R = 2^len
- modulus  in  32  shared modulus, stable while busy
- done  out  NREQ  one-cycle completion pulse to served requester
- rsp_valid  out  1  one-cycle pulse, coincident with done
- rsp_id  out  3  index of served requester
- rsp_data  out  32  conversion result (0 on error)
- rsp_err  out  1  request rejected or timed out
- busy  out  1  high in any state except IDLE
- eng_start  out  1  one-cycle start pulse to engine
- eng_num  out  32  latched operand to engine
- eng_len  out  8  latched len to engine
- eng_mod  out  32  latched modulus to engine
- eng_end  in  1  engine completion pulse
- eng_out  in  32  engine result, valid when eng_end=1

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if any req bit set, select first set bit searching from ptr upward mod NREQ; latch id, req_num slice, req_len slice, modulus; ptr <= id+1 mod NREQ.
  - Valid (len <= 31 and modulus != 0): go LAUNCH.
  - Invalid: go RESP with rsp_err=1, rsp_data=0; engine never started.
- LAUNCH: eng_start=1 for exactly this cycle; go WAIT.
- WAIT: on eng_end=1 capture eng_out into rsp_data, rsp_err=0, go RESP.
- RESP: done[id]=1, rsp_valid=1, rsp_id=id for one cycle; go IDLE.
- eng_end outside WAIT ignored.
- Requester holds req and operands until done sampled high; it must drop req on that same edge. IDLE lasts at least one cycle between grants.
- Requests arriving while busy wait; no queueing beyond req level.
- eng_num/eng_len/eng_mod hold latched values from LAUNCH until next grant.
- Reset (any state, including mid-WAIT): state IDLE, ptr 0, all outputs 0 (done, rsp_valid, rsp_id, rsp_data, rsp_err, busy, eng_start, eng_num, eng_len, eng_mod).

## Timing
- All outputs registered.
- Valid request: req seen in IDLE cycle T; eng_start high in T+1; WAIT from T+2; eng_end at cycle E; done/rsp_valid in E+1; IDLE in E+2.
- Invalid request: req at T; done/rsp_valid with rsp_err=1 in T+1; IDLE in T+2.
- Back-to-back: next grant decision in the IDLE cycle after RESP; minimum 4 cycles per valid request plus engine latency.
- busy rises in the cycle after grant decision, falls in the cycle after RESP.

## Configuration
- MC_TIMEOUT_EN defined: 16-bit counter cleared in LAUNCH, incremented each WAIT cycle; if it reaches TIMEOUT_CYC without eng_end, go RESP with rsp_err=1, rsp_data=0. A late eng_end is ignored.
- Undefined: no counter; WAIT persists until eng_end; TIMEOUT_CYC unused.

## Test plan
- req[0], num=5, len=4, mod=7, engine model returns 80 mod 7 -> eng_start single pulse one cycle after grant, eng_num=5/eng_len=4, done[0] one cycle, rsp_id=0, rsp_data=3, rsp_err=0.
- req=4'b1111 held, each dropped on its done -> service order 0,1,2,3; then req=4'b0101 -> order 0,2.
- req[1] with len=32 -> rsp_err=1, rsp_data=0, no eng_start, done[1] one cycle after grant; same for modulus=0.
- MC_TIMEOUT_EN, TIMEOUT_CYC=16, engine never ends -> rsp_err=1 after 16 WAIT cycles; eng_end pulse injected 3 cycles later ignored, busy=0.
- rstn low mid-WAIT -> all outputs 0 immediately; after release req[3], num=1, len=8, mod=251 -> grant 3, rsp_data=5.
- eng_end pulsed while IDLE -> no rsp_valid, no state change.
